flit_sink: RTL
==============

FLIT_SINK -- requirements
Module: flit_sink

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk     input   1           rising-edge clock
  rst_    input   1           asynchronous reset, active-low
  idata   input   `DATAW_P1   flit from mux odata; type field idata[`DATAW:`DATAW-2], payload below it
  ivalid  input   1           flit qualifier
  ivch    input   `VCHW_P1    flit virtual channel
  enable  input   1           measurement window; counters advance only while high
  clear   input   1           synchronous clear of all counters and error state
  busy    output  1           packet in progress (FSM in BODY)
  pkt_cnt output  32          packets completed with a valid TAIL
  flit_cnt output 32          valid flits accepted
  act_cnt output  32          cycles with ivalid=1 while enable=1
  cyc_cnt output  32          cycles with enable=1
  last_len output 16          flit count of last completed packet, HEAD and TAIL included
  last_dst output 32          idata[31:0] of the last HEAD
  err_cnt output 16           framing errors
  err     output  1           sticky error flag
  tgl_cnt output  32          payload bit toggles between consecutive valid flits
REQ-003 Type codes SHALL be `TYPE_HEAD, `TYPE_DATA, `TYPE_TAIL and `TYPE_NONE from define_temp.v.

Function
REQ-004 The block SHALL always accept the flit (no back-pressure); the flit is sampled on the rising clk edge when ivalid=1.
REQ-005 FSM states SHALL be IDLE and BODY.
REQ-006 In IDLE, on valid HEAD: go to BODY; len=1; latch ivch and idata[31:0] into last_dst.
REQ-007 In IDLE, on valid DATA, TAIL or NONE: err_cnt+1, err=1, remain in IDLE.
REQ-008 In BODY, on valid DATA: len+1.
REQ-009 In BODY, on valid TAIL: pkt_cnt+1, last_len=len+1, go to IDLE.
REQ-010 In BODY, on valid HEAD (truncated packet): err_cnt+1, then restart per REQ-006.
REQ-011 In BODY, on valid NONE: err_cnt+1; stay in BODY; len unchanged.
REQ-012 In BODY, an ivch differing from the latched vch on DATA or TAIL: err_cnt+1; the flit is processed normally.
REQ-013 Error counting SHALL obey these rules: at most one err_cnt increment per cycle; err_cnt saturates at 16'hFFFF; len saturates at 16'hFFFF.
REQ-014 Cycles with ivalid=0 SHALL not change FSM, len or toggle history.
REQ-015 Counter gating SHALL obey these rules: FSM transitions and last_dst/last_len always update; pkt_cnt, flit_cnt, act_cnt, cyc_cnt, err_cnt and tgl_cnt advance only while enable=1; 32-bit counters wrap.
REQ-016 All outputs SHALL be registered and reflect a flit one cycle after the sampling edge.
REQ-017 The clear input SHALL take priority over a simultaneous flit. It zeroes all counters, err, last_len and last_dst, forces IDLE, and clears toggle history.

Reset
REQ-018 rst_=0 SHALL asynchronously force IDLE, busy=0, err=0, all counters, last_len, last_dst and toggle history to 0, including mid-packet.
REQ-019 After rst_ deasserts, the first valid non-HEAD flit SHALL count as an error per REQ-007.

Configuration
REQ-020 Toggle counting SHALL be controlled by the macro FLIT_SINK_TOGGLE_EN.
REQ-021 With FLIT_SINK_TOGGLE_EN defined: on each valid flit after the first since reset or clear, tgl_cnt SHALL add the popcount of (payload XOR previous valid payload); the payload excludes the type field. The first valid flit only loads history.
REQ-022 Without FLIT_SINK_TOGGLE_EN: the tgl_cnt port SHALL remain and be tied to 0, and no history register or popcount logic SHALL be built.

Verification
REQ-023 enable=1; HEAD(dst 32'h04) + 20 DATA + TAIL on vch 0 -> pkt_cnt=1, last_len=22, last_dst=32'h04, flit_cnt=22, err=0.
REQ-024 10 such packets, each followed by 8 invalid cycles -> pkt_cnt=10, act_cnt=220, cyc_cnt=300, err_cnt=0.
REQ-025 DATA with no preceding HEAD, then HEAD, 3 DATA, HEAD, TAIL -> err_cnt=2, pkt_cnt=1, last_len=2.
REQ-026 HEAD on vch 0, DATA on vch 1, TAIL on vch 0 -> err_cnt=1, pkt_cnt=1, last_len=3.
REQ-027 FLIT_SINK_TOGGLE_EN defined; 46 low payload bits alternate all-0 and all-1 over 5 valid flits, upper payload constant -> tgl_cnt=184; macro undefined -> tgl_cnt=0.
REQ-028 rst_ pulsed low after HEAD + 5 DATA, followed by TAIL -> busy=0 immediately, then err_cnt=1, pkt_cnt=0.

Source files
------------

// File: rtl/flit_sink.sv
// ---------------------------------------------------------------------------
// flit_sink
//
// Terminates a flit stream and collects traffic statistics. A small IDLE/BODY
// framing FSM tracks packets (HEAD, DATA*, TAIL). Framing and virtual-channel
// errors are counted. Flits are always accepted; there is no back-pressure.
//
// Configuration macro: FLIT_SINK_TOGGLE_EN
//   defined   -> tgl_cnt accumulates payload bit toggles between consecutive
//                valid flits
//   undefined -> tgl_cnt is tied to 0 and no history/popcount logic exists
//
// Width and type-code macros normally come from define_temp.v. The defaults
// below apply only when that file has not been included first.
//
// Ports:
//   clk       rising-edge clock
//   rst_      asynchronous reset, active-low
//   idata     flit; type in idata[`DATAW:`DATAW-2], payload below it
//   ivalid    flit qualifier
//   ivch      flit virtual channel
//   enable    measurement window; statistics counters advance only while high
//   clear     synchronous clear of counters, error state and framing state
//   busy      packet in progress
//   pkt_cnt   packets closed by a TAIL
//   flit_cnt  valid flits accepted
//   act_cnt   cycles with ivalid=1 while enable=1
//   cyc_cnt   cycles with enable=1
//   last_len  flit count of the last completed packet (HEAD and TAIL included)
//   last_dst  idata[31:0] of the last HEAD
//   err_cnt   framing errors (saturating)
//   err       sticky error flag
//   tgl_cnt   payload bit toggles between consecutive valid flits
// ---------------------------------------------------------------------------
`ifndef DATAW
`define DATAW 63
`endif
`ifndef DATAW_P1
`define DATAW_P1 64
`endif
`ifndef VCHW
`define VCHW 1
`endif
`ifndef VCHW_P1
`define VCHW_P1 2
`endif
`ifndef TYPE_NONE
`define TYPE_NONE 3'd0
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 3'd1
`endif
`ifndef TYPE_DATA
`define TYPE_DATA 3'd2
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 3'd3
`endif

module flit_sink (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic [`DATAW_P1-1:0] idata,
    input  logic                 ivalid,
    input  logic [`VCHW_P1-1:0]  ivch,
    input  logic                 enable,
    input  logic                 clear,
    output logic                 busy,
    output logic [31:0]          pkt_cnt,
    output logic [31:0]          flit_cnt,
    output logic [31:0]          act_cnt,
    output logic [31:0]          cyc_cnt,
    output logic [15:0]          last_len,
    output logic [31:0]          last_dst,
    output logic [15:0]          err_cnt,
    output logic                 err,
    output logic [31:0]          tgl_cnt
);

    localparam int PAYW = `DATAW - 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [2:0]          w_type;
    logic                w_is_head;
    logic                w_is_data;
    logic                w_is_tail;
    logic                w_vch_bad;

    logic                w_head_evt;
    logic                w_data_evt;
    logic                w_tail_evt;
    logic                w_err_evt;

    logic [15:0]         r_len;
    logic [15:0]         w_len_inc;
    logic [`VCHW_P1-1:0] r_vch;

    logic [31:0]         r_pkt_cnt;
    logic [31:0]         r_flit_cnt;
    logic [31:0]         r_act_cnt;
    logic [31:0]         r_cyc_cnt;
    logic [15:0]         r_last_len;
    logic [31:0]         r_last_dst;
    logic [15:0]         r_err_cnt;
    logic                r_err;

    assign w_type    = idata[`DATAW:`DATAW-2];
    assign w_is_head = (w_type == `TYPE_HEAD);
    assign w_is_data = (w_type == `TYPE_DATA);
    assign w_is_tail = (w_type == `TYPE_TAIL);
    assign w_vch_bad = (ivch != r_vch);
    assign w_len_inc = (r_len == 16'hFFFF) ? r_len : r_len + 16'd1;

    // -----------------------------------------------------------------------
    // FSM: state register (clear forces IDLE ahead of any flit)
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= ST_IDLE;
        end else if (clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state. A HEAD in BODY restarts the packet, so BODY is kept.
    always_comb begin
        w_state_nxt = r_state;
        if (ivalid) begin
            case (r_state)
                ST_IDLE: if (w_is_head) w_state_nxt = ST_BODY;
                ST_BODY: if (w_is_tail) w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM: per-flit event strobes. Any type code other than HEAD/DATA/TAIL is
    // handled like NONE. Every path raises at most one error strobe.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        w_head_evt = 1'b0;
        w_data_evt = 1'b0;
        w_tail_evt = 1'b0;
        w_err_evt  = 1'b0;
        if (ivalid) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_head) w_head_evt = 1'b1;
                    else           w_err_evt  = 1'b1;
                end
                ST_BODY: begin
                    if (w_is_head) begin
                        // Truncated packet: count it, then start the new one.
                        w_err_evt  = 1'b1;
                        w_head_evt = 1'b1;
                    end else if (w_is_data) begin
                        w_data_evt = 1'b1;
                        w_err_evt  = w_vch_bad;
                    end else if (w_is_tail) begin
                        w_tail_evt = 1'b1;
                        w_err_evt  = w_vch_bad;
                    end else begin
                        w_err_evt  = 1'b1;
                    end
                end
                default: w_err_evt = 1'b0;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Packet tracking and statistics
    // Framing state, last_len/last_dst and the sticky err flag follow the
    // traffic at all times; only the counters honour the enable window.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_len      <= '0;
            r_vch      <= '0;
            r_pkt_cnt  <= '0;
            r_flit_cnt <= '0;
            r_act_cnt  <= '0;
            r_cyc_cnt  <= '0;
            r_last_len <= '0;
            r_last_dst <= '0;
            r_err_cnt  <= '0;
            r_err      <= 1'b0;
        end else if (clear) begin
            r_len      <= '0;
            r_vch      <= '0;
            r_pkt_cnt  <= '0;
            r_flit_cnt <= '0;
            r_act_cnt  <= '0;
            r_cyc_cnt  <= '0;
            r_last_len <= '0;
            r_last_dst <= '0;
            r_err_cnt  <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_head_evt) begin
                r_len      <= 16'd1;
                r_vch      <= ivch;
                r_last_dst <= idata[31:0];
            end else if (w_data_evt) begin
                r_len <= w_len_inc;
            end

            if (w_tail_evt) r_last_len <= w_len_inc;
            if (w_err_evt)  r_err      <= 1'b1;

            if (enable) begin
                r_cyc_cnt <= r_cyc_cnt + 32'd1;
                if (ivalid) begin
                    r_act_cnt  <= r_act_cnt + 32'd1;
                    r_flit_cnt <= r_flit_cnt + 32'd1;
                end
                if (w_tail_evt) r_pkt_cnt <= r_pkt_cnt + 32'd1;
                if (w_err_evt && (r_err_cnt != 16'hFFFF)) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
            end
        end
    end

    assign busy     = (r_state == ST_BODY);
    assign pkt_cnt  = r_pkt_cnt;
    assign flit_cnt = r_flit_cnt;
    assign act_cnt  = r_act_cnt;
    assign cyc_cnt  = r_cyc_cnt;
    assign last_len = r_last_len;
    assign last_dst = r_last_dst;
    assign err_cnt  = r_err_cnt;
    assign err      = r_err;

    // -----------------------------------------------------------------------
    // Payload toggle counter
    // -----------------------------------------------------------------------
`ifdef FLIT_SINK_TOGGLE_EN
    logic [PAYW-1:0] r_hist;
    logic            r_hist_vld;
    logic [31:0]     r_tgl_cnt;
    logic [PAYW-1:0] w_diff;
    logic [31:0]     w_tgl_pop;

    assign w_diff = idata[PAYW-1:0] ^ r_hist;

    always_comb begin
        w_tgl_pop = '0;
        for (int i = 0; i < PAYW; i++) begin
            w_tgl_pop = w_tgl_pop + {31'd0, w_diff[i]};
        end
    end

    // History follows every valid flit; only the accumulation is gated.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_hist     <= '0;
            r_hist_vld <= 1'b0;
            r_tgl_cnt  <= '0;
        end else if (clear) begin
            r_hist     <= '0;
            r_hist_vld <= 1'b0;
            r_tgl_cnt  <= '0;
        end else if (ivalid) begin
            r_hist     <= idata[PAYW-1:0];
            r_hist_vld <= 1'b1;
            if (enable && r_hist_vld) r_tgl_cnt <= r_tgl_cnt + w_tgl_pop;
        end
    end

    assign tgl_cnt = r_tgl_cnt;
`else
    // Upper payload bits only feed the toggle logic.
    logic w_unused_payload;
    assign w_unused_payload = ^idata[PAYW-1:32];
    assign tgl_cnt = '0;
`endif

endmodule
